// File: rtl/ram_2p_port_arbiter.sv
// Round-robin arbiter in front of one RAM port, with a zero-fill sweep
// that runs after reset (optional) and on request. Responses come back
// one cycle after each grant, tagged one-hot to the granted requester.
module ram_2p_port_arbiter #(
    parameter int NumReq       = 2,
    parameter int Width        = 32,
    parameter int Depth        = 128,
    parameter bit ClearOnReset = 1'b1,
    localparam int Aw          = (Depth > 1) ? $clog2(Depth) : 1
) (
    input  logic                     clk_i,
    input  logic                     rst_ni,
    input  logic                     clear_i,
    output logic                     busy_o,
    input  logic [NumReq-1:0]        req_i,
    input  logic [NumReq-1:0]        we_i,
    input  logic [NumReq*Aw-1:0]     addr_i,
    input  logic [NumReq*Width-1:0]  wdata_i,
    input  logic [NumReq*Width-1:0]  wmask_i,
    output logic [NumReq-1:0]        gnt_o,
    output logic [NumReq-1:0]        rvalid_o,
    output logic [Width-1:0]         rdata_o,
    output logic                     ram_req_o,
    output logic                     ram_write_o,
    output logic [Aw-1:0]            ram_addr_o,
    output logic [Width-1:0]         ram_wdata_o,
    output logic [Width-1:0]         ram_wmask_o,
    input  logic [Width-1:0]         ram_rdata_i
);

    localparam int Iw = (NumReq > 1) ? $clog2(NumReq) : 1;

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_CLEAR = 1'b1
    } state_t;

    state_t            state_reg;
    logic [Aw-1:0]     cnt_reg;
    logic [Iw-1:0]     last_reg;
    logic [NumReq-1:0] rvalid_reg;

    logic              any_req;
    logic [Iw-1:0]     win_idx;
    int                cand;

    // Round-robin search starting just after the last granted requester.
    always_comb begin
        any_req = 1'b0;
        win_idx = '0;
        cand    = 0;
        if (state_reg == ST_IDLE) begin
            for (int k = 1; k <= NumReq; k++) begin
                cand = (int'(last_reg) + k) % NumReq;
                if (!any_req && req_i[cand]) begin
                    any_req = 1'b1;
                    win_idx = Iw'(cand);
                end
            end
        end
    end

    // One-hot grant to the winner; nobody is granted during a sweep.
    always_comb begin
        gnt_o = '0;
        if (any_req) begin
            gnt_o[win_idx] = 1'b1;
        end
    end

    // RAM port mux: sweep writes zeros, otherwise the winner's payload passes.
    always_comb begin
        ram_req_o   = 1'b0;
        ram_write_o = 1'b0;
        ram_addr_o  = '0;
        ram_wdata_o = '0;
        ram_wmask_o = '0;
        if (state_reg == ST_CLEAR) begin
            ram_req_o   = 1'b1;
            ram_write_o = 1'b1;
            ram_addr_o  = cnt_reg;
            ram_wmask_o = '1;
        end else if (any_req) begin
            ram_req_o   = 1'b1;
            ram_write_o = we_i[win_idx];
            ram_addr_o  = addr_i[int'(win_idx)*Aw +: Aw];
            ram_wdata_o = wdata_i[int'(win_idx)*Width +: Width];
            ram_wmask_o = wmask_i[int'(win_idx)*Width +: Width];
        end
    end

    // Response tagging and round-robin pointer update on every grant.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            rvalid_reg <= '0;
            last_reg   <= Iw'(NumReq - 1);
        end else begin
            rvalid_reg <= gnt_o;
            if (any_req) begin
                last_reg <= win_idx;
            end
        end
    end

    // Sweep sequencer: count 0..Depth-1 in CLEAR, then fall back to IDLE.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_reg <= ClearOnReset ? ST_CLEAR : ST_IDLE;
            cnt_reg   <= '0;
        end else begin
            case (state_reg)
                ST_CLEAR: begin
                    if (cnt_reg == Aw'(Depth - 1)) begin
                        state_reg <= ST_IDLE;
                        cnt_reg   <= '0;
                    end else begin
                        cnt_reg <= cnt_reg + 1'b1;
                    end
                end
                ST_IDLE: begin
                    if (clear_i) begin
                        state_reg <= ST_CLEAR;
                    end
                end
                default: state_reg <= ST_IDLE;
            endcase
        end
    end

    assign rvalid_o = rvalid_reg;
    assign rdata_o  = ram_rdata_i;
    assign busy_o   = (state_reg == ST_CLEAR);

endmodule

// File: tb/tb_ram_2p_port_arbiter.sv
// Randomized scoreboard bench for ram_2p_port_arbiter with a behavioural
// RAM attached to the arbitrated port.
module tb_ram_2p_port_arbiter;

    localparam int NR    = 2;
    localparam int W     = 32;
    localparam int DEPTH = 128;
    localparam int AW    = $clog2(DEPTH);

    logic              clk_i = 1'b0;
    logic              rst_ni;
    logic              clear_i;
    logic              busy_o;
    logic [NR-1:0]     req_i;
    logic [NR-1:0]     we_i;
    logic [NR*AW-1:0]  addr_i;
    logic [NR*W-1:0]   wdata_i;
    logic [NR*W-1:0]   wmask_i;
    logic [NR-1:0]     gnt_o;
    logic [NR-1:0]     rvalid_o;
    logic [W-1:0]      rdata_o;
    logic              ram_req_o;
    logic              ram_write_o;
    logic [AW-1:0]     ram_addr_o;
    logic [W-1:0]      ram_wdata_o;
    logic [W-1:0]      ram_wmask_o;
    logic [W-1:0]      ram_rdata_i;

    ram_2p_port_arbiter #(
        .NumReq(NR), .Width(W), .Depth(DEPTH), .ClearOnReset(1'b1)
    ) dut (
        .clk_i(clk_i), .rst_ni(rst_ni), .clear_i(clear_i), .busy_o(busy_o),
        .req_i(req_i), .we_i(we_i), .addr_i(addr_i), .wdata_i(wdata_i),
        .wmask_i(wmask_i), .gnt_o(gnt_o), .rvalid_o(rvalid_o), .rdata_o(rdata_o),
        .ram_req_o(ram_req_o), .ram_write_o(ram_write_o), .ram_addr_o(ram_addr_o),
        .ram_wdata_o(ram_wdata_o), .ram_wmask_o(ram_wmask_o), .ram_rdata_i(ram_rdata_i)
    );

    always #5 clk_i = ~clk_i;

    // Behavioural single-port RAM: one-cycle read latency, bit-masked write.
    logic [W-1:0] ram_mem [DEPTH];
    always @(posedge clk_i) begin
        if (ram_req_o) begin
            if (ram_write_o)
                ram_mem[ram_addr_o] <= (ram_mem[ram_addr_o] & ~ram_wmask_o) | (ram_wdata_o & ram_wmask_o);
            else
                ram_rdata_i <= ram_mem[ram_addr_o];
        end
    end

    longint cyc = 0;
    always @(posedge clk_i) cyc <= cyc + 1;

    typedef struct {
        int          idx;
        bit          rd;
        logic [W-1:0] data;
        longint      due;
    } exp_t;

    exp_t         q[$];
    int           checks = 0;
    int           failures = 0;
    logic [W-1:0] mem_ref [DEPTH];
    int           m_busy_left;
    int           m_last;
    logic         g_busy;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h required=%h t=%0t", name, act, exp, $time);
        end
    endtask

    // One cycle of stimulus; reference model decides grant and response.
    task automatic step(input logic [NR-1:0] req, input logic [NR-1:0] we,
                        input logic [NR*AW-1:0] addr, input logic [NR*W-1:0] wd,
                        input logic [NR*W-1:0] wm, input logic clr);
        int win;
        int a;
        exp_t e;
        logic [W-1:0] d, m;
        @(negedge clk_i);
        req_i = req; we_i = we; addr_i = addr; wdata_i = wd; wmask_i = wm; clear_i = clr;
        #1;
        g_busy = busy_o;
        chk("busy", 64'(busy_o), 64'(m_busy_left > 0));
        if (m_busy_left > 0) begin
            a = DEPTH - m_busy_left;
            chk("gnt_during_clear", 64'(gnt_o), 64'd0);
            chk("sweep_addr", 64'(ram_addr_o), 64'(a));
            chk("sweep_req_write", 64'({ram_req_o, ram_write_o, ram_wmask_o}), 64'({2'b11, 32'hFFFF_FFFF}));
            chk("sweep_wdata", 64'(ram_wdata_o), 64'd0);
            mem_ref[a] = '0;
            m_busy_left--;
        end else begin
            win = -1;
            for (int k = 1; k <= NR; k++) begin
                int i;
                i = (m_last + k) % NR;
                if (win < 0 && req[i]) win = i;
            end
            chk("gnt", 64'(gnt_o), (win < 0) ? 64'd0 : (64'd1 << win));
            if (win < 0) begin
                chk("ram_req_idle", 64'(ram_req_o), 64'd0);
            end else begin
                a = int'(addr[win*AW +: AW]);
                d = wd[win*W +: W];
                m = wm[win*W +: W];
                chk("ram_addr", 64'(ram_addr_o), 64'(a));
                chk("ram_write", 64'(ram_write_o), 64'(we[win]));
                e.idx = win; e.rd = !we[win]; e.data = mem_ref[a]; e.due = cyc + 1;
                q.push_back(e);
                if (we[win]) mem_ref[a] = (mem_ref[a] & ~m) | (d & m);
                m_last = win;
            end
            if (clr) m_busy_left = DEPTH;
        end
    endtask

    task automatic do_reset(input int n);
        @(negedge clk_i);
        rst_ni = 1'b0;
        req_i = '0; we_i = '0; clear_i = 1'b0;
        q.delete();
        m_busy_left = DEPTH;
        m_last = NR - 1;
        mem_ref[0] = '0;
        repeat (n) begin
            @(negedge clk_i); #1;
            chk("rst_busy", 64'(busy_o), 64'd1);
            chk("rst_rvalid", 64'(rvalid_o), 64'd0);
        end
        @(posedge clk_i); #2;
        rst_ni = 1'b1;
    endtask

    task automatic count_sweep(input logic [NR-1:0] req, input logic [NR*AW-1:0] addr, output int n);
        bit seen;
        n = 0; seen = 1;
        while (seen && n < 300) begin
            step(req, '0, addr, '0, '1, 1'b0);
            if (g_busy) n++; else seen = 0;
        end
    endtask

    // Monitor: every cycle compare rvalid/rdata with the scoreboard head.
    initial begin
        forever begin
            logic [NR-1:0] exp_v;
            exp_t e;
            @(negedge clk_i); #3;
            if (!rst_ni) continue;
            exp_v = '0;
            if (q.size() > 0 && q[0].due <= cyc) exp_v = NR'(1 << q[0].idx);
            chk("rvalid", 64'(rvalid_o), 64'(exp_v));
            if (exp_v != '0) begin
                e = q.pop_front();
                $display("rsp cyc=%0d idx=%0d rd=%0d rdata=%h", cyc, e.idx, e.rd, rdata_o);
                if (e.rd) chk("rdata", 64'(rdata_o), 64'(e.data));
            end
        end
    end

    initial begin
        int n;
        int nz;
        for (int i = 0; i < DEPTH; i++) begin
            ram_mem[i] = 32'hFFFF_FFFF;
            mem_ref[i] = 32'hFFFF_FFFF;
        end
        req_i = '0; we_i = '0; addr_i = '0; wdata_i = '0; wmask_i = '0; clear_i = 1'b0;
        rst_ni = 1'b1;
        #1 rst_ni = 1'b0;

        // Reset, partial sweep, reset mid-sweep, full sweep.
        do_reset(3);
        repeat (60) step('0, '0, '0, '0, '0, 1'b0);
        do_reset(2);
        count_sweep('0, '0, n);
        chk("sweep_len_after_reset", 64'(n), 64'(DEPTH));
        nz = 0;
        for (int i = 0; i < DEPTH; i++) if (ram_mem[i] !== '0) nz++;
        chk("mem_zero_after_sweep", 64'(nz), 64'd0);

        // Read address 5 after sweep, then latency / write-read.
        step(2'b01, 2'b00, {7'd0, 7'd5}, '0, '1, 1'b0);
        step(2'b01, 2'b01, {7'd0, 7'd3}, {32'h0, 32'hDEAD_BEEF}, '1, 1'b0);
        step(2'b01, 2'b00, {7'd0, 7'd3}, '0, '1, 1'b0);

        // Contention: both requesting for 4 cycles.
        repeat (4) step(2'b11, 2'b00, {7'd2, 7'd3}, '0, '1, 1'b0);

        // Partial mask write.
        step(2'b01, 2'b01, {7'd0, 7'd7}, {32'h0, 32'hAABB_CCDD}, '1, 1'b0);
        step(2'b01, 2'b01, {7'd0, 7'd7}, {32'h0, 32'h1122_3344}, {32'h0, 32'h0000_FFFF}, 1'b0);
        step(2'b01, 2'b00, {7'd0, 7'd7}, '0, '1, 1'b0);
        step('0, '0, '0, '0, '0, 1'b0);

        // On-demand clear while requester 1 reads address 10.
        step(2'b10, 2'b00, {7'd10, 7'd0}, '0, '1, 1'b1);
        count_sweep(2'b11, {7'd10, 7'd10}, n);
        chk("sweep_len_on_demand", 64'(n), 64'(DEPTH));
        step(2'b10, 2'b00, {7'd10, 7'd0}, '0, '1, 1'b0);

        // Randomized traffic with occasional clears.
        repeat (400) begin
            step(NR'($urandom), NR'($urandom),
                 {7'($urandom_range(0, DEPTH-1)), 7'($urandom_range(0, DEPTH-1))},
                 {$urandom, $urandom}, {$urandom, $urandom},
                 ($urandom_range(0, 199) == 0));
        end

        // Drain and finish.
        repeat (DEPTH + 3) step('0, '0, '0, '0, '0, 1'b0);
        chk("scoreboard_drained", 64'(q.size()), 64'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
